// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-port arbiter and its
// helpers: register address/data widths, the hard-wired zero register,
// the arbiter state encoding and a saturating drop-counter increment.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int DROP_W     = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Arbiter states: ARB rotates priority, LOCK parks the port on one owner.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] drop_cnt_sat_inc(input logic [DROP_W-1:0] cnt);
        logic [DROP_W-1:0] result;
        if (cnt == 16'hFFFF) begin
            result = cnt;
        end else begin
            result = cnt + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational rotating-priority picker. Starting at ptr_i and
// moving upward modulo NUM_REQ, the first set bit of req_i wins.
//
// Ports:
//   req_i    [NUM_REQ]  request vector
//   ptr_i    [IDX_W]    index with highest priority this cycle
//   grant_o  [NUM_REQ]  one-hot grant, zero when req_i is zero
//   idx_o    [IDX_W]    index of the granted bit (0 when nothing granted)
// NUM_REQ must be a power of two so that index arithmetic wraps naturally.
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand_s;

    // Walk the offsets from farthest to nearest so the nearest requester
    // at or above ptr_i is the last (winning) assignment.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand_s  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = ptr_i + IDX_W'(k);
            if (req_i[cand_s]) begin
                idx_o = cand_s;
            end else begin
                idx_o = idx_o;
            end
        end
        if (|req_i) begin
            grant_o[idx_o] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single write port of a 32x32 register file between NUM_REQ
// writeback sources with a rotating-priority arbiter and an optional bounded
// lock. Accepted writes are presented to the register file one cycle later.
// Writes to register 0 are accepted and counted but never issued.
//
// Ports:
//   Clk, Reset      clock; synchronous active-high reset
//   ReqValid/ReqLock  per-requester pending write / keep-port request
//   ReqAddr/ReqData   per-requester destination and data (packed slices)
//   ReqReady        combinational one-hot (or zero) grant
//   WriteRegister, WriteData, RegWrite   registered regfile write port
//   GrantId         index of the last accepted requester (registered)
//   DropCount       saturating count of accepted writes to register 0
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4,
    parameter int GID_W     = $clog2(NUM_REQ)
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             ReqValid,
    input  logic [NUM_REQ-1:0]             ReqLock,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]  ReqAddr,
    input  logic [NUM_REQ*REG_DATA_W-1:0]  ReqData,
    output logic [NUM_REQ-1:0]             ReqReady,
    output logic [REG_ADDR_W-1:0]          WriteRegister,
    output logic [REG_DATA_W-1:0]          WriteData,
    output logic                           RegWrite,
    output logic [GID_W-1:0]               GrantId,
    output logic [DROP_W-1:0]              DropCount
);

    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;

    // Arbiter state
    arb_state_e         state_q, state_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;
    logic [GID_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    // Registered write port
    logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [REG_DATA_W-1:0] wr_data_q, wr_data_d;
    logic                  reg_write_q, reg_write_d;
    logic [GID_W-1:0]      gid_q, gid_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

    // Combinational arbitration
    logic [NUM_REQ-1:0]    pick_grant_s;
    logic [GID_W-1:0]      pick_idx_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic                  owner_valid_s;
    logic                  xfer_s;
    logic [GID_W-1:0]      xfer_idx_s;
    logic [REG_ADDR_W-1:0] sel_addr_s;
    logic [REG_DATA_W-1:0] sel_data_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GID_W)
    ) u_picker (
        .req_i   (ReqValid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s)
    );

    assign owner_valid_s = ReqValid[owner_q];
    assign xfer_s        = |(ReqValid & ready_s);
    assign xfer_idx_s    = (state_q == LOCK) ? owner_q : pick_idx_s;

    // Grant generation: rotating pick in ARB, owner-only in LOCK, none in reset.
    always_comb begin
        ready_s = '0;
        if (Reset) begin
            ready_s = '0;
        end else if (state_q == LOCK) begin
            ready_s[owner_q] = owner_valid_s;
        end else begin
            ready_s = pick_grant_s;
        end
    end

    // Select address/data of the transferring requester only, so other
    // requesters' buses can never leak into the outputs.
    always_comb begin
        sel_addr_s = REG_ZERO;
        sel_data_s = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer_idx_s == GID_W'(i)) begin
                sel_addr_s = ReqAddr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data_s = ReqData[i*REG_DATA_W +: REG_DATA_W];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state logic for the arbiter FSM and the write-port stage.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        gid_d       = gid_q;
        drop_cnt_d  = drop_cnt_q;
        reg_write_d = 1'b0;

        case (state_q)
            ARB: begin
                if (xfer_s) begin
                    ptr_d = pick_idx_s + GID_W'(1);
                    if (ReqLock[pick_idx_s] && (BURST_MAX > 1)) begin
                        state_d     = LOCK;
                        owner_d     = pick_idx_s;
                        burst_cnt_d = CNT_W'(1);
                    end else begin
                        state_d = ARB;
                    end
                end else begin
                    state_d = ARB;
                end
            end
            LOCK: begin
                if (!owner_valid_s) begin
                    // Owner went idle: give the port back without a transfer.
                    state_d = ARB;
                    ptr_d   = owner_q + GID_W'(1);
                end else begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (!ReqLock[owner_q] || (burst_cnt_d == CNT_W'(BURST_MAX))) begin
                        state_d = ARB;
                        ptr_d   = owner_q + GID_W'(1);
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase

        if (xfer_s) begin
            wr_reg_d    = sel_addr_s;
            wr_data_d   = sel_data_s;
            gid_d       = xfer_idx_s;
            reg_write_d = (sel_addr_s != REG_ZERO);
            if (sel_addr_s == REG_ZERO) begin
                drop_cnt_d = drop_cnt_sat_inc(drop_cnt_q);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            reg_write_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            wr_reg_q    <= REG_ZERO;
            wr_data_q   <= 32'd0;
            reg_write_q <= 1'b0;
            gid_q       <= '0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            reg_write_q <= reg_write_d;
            gid_q       <= gid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign ReqReady      = ready_s;
    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_data_q;
    assign GrantId       = gid_q;
    assign DropCount     = drop_cnt_q;
    // A write still in flight when Reset rises is cancelled before the
    // regfile samples it on that same edge.
    assign RegWrite      = reg_write_q & ~Reset;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int BM = 4;
    localparam int GW = 2;

    logic          Clk;
    logic          Reset;
    logic [N-1:0]  ReqValid;
    logic [N-1:0]  ReqLock;
    logic [N*5-1:0]  ReqAddr;
    logic [N*32-1:0] ReqData;
    logic [N-1:0]  ReqReady;
    logic [4:0]    WriteRegister;
    logic [31:0]   WriteData;
    logic          RegWrite;
    logic [GW-1:0] GrantId;
    logic [15:0]   DropCount;

    int tests_run    = 0;
    int tests_failed = 0;
    int step_no      = 0;

    regfile_write_arbiter #(
        .NUM_REQ   (N),
        .BURST_MAX (BM),
        .GID_W     (GW)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ReqValid      (ReqValid),
        .ReqLock       (ReqLock),
        .ReqAddr       (ReqAddr),
        .ReqData       (ReqData),
        .ReqReady      (ReqReady),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .GrantId       (GrantId),
        .DropCount     (DropCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file driven by the DUT's write port; r0 is never written.
    logic [31:0] tb_rf [32];
    logic        rf_clr;
    always @(posedge Clk) begin
        if (rf_clr) begin
            for (int k = 0; k < 32; k++) tb_rf[k] <= 32'd0;
        end else if (RegWrite && WriteRegister != 5'd0) begin
            tb_rf[WriteRegister] <= WriteData;
        end
    end

    // Reference model state
    int          m_ptr, m_owner, m_burst, m_gid, m_drop;
    bit          m_locked, m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_rf [32];
    logic [N-1:0] last_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_burst = 0; m_locked = 0;
        m_rw = 0; m_wreg = 5'd0; m_wdata = 32'd0; m_gid = 0; m_drop = 0;
    endtask

    // One clock: drive inputs, check the grant, advance the model, check outputs.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [N*5-1:0] a, input logic [N*32-1:0] d);
        logic [N-1:0] exp_rdy;
        int g;
        int chk;
        Reset = rst; ReqValid = v; ReqLock = l; ReqAddr = a; ReqData = d;
        #1;
        exp_rdy = '0;
        if (!rst) begin
            if (m_locked) begin
                if (v[m_owner]) exp_rdy[m_owner] = 1'b1;
            end else begin
                for (int off = 0; off < N; off++) begin
                    int i;
                    i = (m_ptr + off) % N;
                    if (v[i] && exp_rdy == '0) exp_rdy[i] = 1'b1;
                end
            end
        end
        last_ready = ReqReady;
        check("ready", 32'(ReqReady), 32'(exp_rdy));

        // Regfile captures the previously registered write unless Reset cancels it.
        if (m_rw && !rst && m_wreg != 5'd0) m_rf[m_wreg] = m_wdata;

        if (rst) begin
            model_reset();
        end else begin
            g = -1;
            for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
            m_rw = 0;
            if (g >= 0) begin
                m_wreg  = a[g*5 +: 5];
                m_wdata = d[g*32 +: 32];
                m_gid   = g;
                m_rw    = (m_wreg != 5'd0);
                if (m_wreg == 5'd0 && m_drop < 65535) m_drop++;
            end
            if (m_locked) begin
                if (!v[m_owner]) begin
                    m_locked = 0; m_ptr = (m_owner + 1) % N;
                end else begin
                    m_burst++;
                    if (!l[m_owner] || m_burst == BM) begin
                        m_locked = 0; m_ptr = (m_owner + 1) % N;
                    end
                end
            end else if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (l[g] && BM > 1) begin
                    m_locked = 1; m_owner = g; m_burst = 1;
                end
            end
        end

        @(posedge Clk);
        #1;
        check("RegWrite",      32'(RegWrite),      32'(m_rw));
        check("WriteRegister", 32'(WriteRegister), 32'(m_wreg));
        check("WriteData",     WriteData,          m_wdata);
        check("GrantId",       32'(GrantId),       32'(m_gid));
        check("DropCount",     32'(DropCount),     32'(m_drop));
        chk = step_no % 32;
        check("regfile", tb_rf[chk], m_rf[chk]);
        step_no++;
    endtask

    initial begin
        logic [N*5-1:0]  a;
        logic [N*32-1:0] d;
        int exp_gid3 [5];
        exp_gid3 = '{1, 1, 1, 1, 2};

        for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
        model_reset();
        rf_clr = 1'b1;
        a = '0; d = '0;

        // 1: reset for two cycles, then a single write from req0
        step(1'b1, 4'b0000, 4'b0000, a, d);
        step(1'b1, 4'b0000, 4'b0000, a, d);
        rf_clr = 1'b0;
        check("t1_reset_drop", 32'(DropCount), 32'd0);
        a[4:0] = 5'd2; d[31:0] = 32'd42;
        step(1'b0, 4'b0001, 4'b0000, a, d);
        check("t1_ready", 32'(last_ready), 32'd1);
        check("t1_regwrite", 32'(RegWrite), 32'd1);
        check("t1_wreg", 32'(WriteRegister), 32'd2);
        check("t1_wdata", WriteData, 32'd42);
        step(1'b0, 4'b0000, 4'b0000, a, d);
        check("t1_rf2", tb_rf[2], 32'd42);

        // 2: all four valid without lock; rotation from a fresh pointer
        step(1'b1, 4'b0000, 4'b0000, a, d);
        for (int i = 0; i < N; i++) begin
            a[i*5 +: 5]  = 5'(i + 1);
            d[i*32 +: 32] = 32'(10 + i);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b1111, 4'b0000, a, d);
            check("t2_gid", 32'(GrantId), 32'(k % 4));
            check("t2_regwrite", 32'(RegWrite), 32'd1);
        end

        // 3: req1 locks for a full burst while req2 waits
        a[5 +: 5] = 5'd6; a[10 +: 5] = 5'd7;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0110, 4'b0010, a, d);
            check("t3_gid", 32'(GrantId), 32'(exp_gid3[k]));
        end

        // 4: two writes to r0 are accepted but dropped
        a[15 +: 5] = 5'd0; d[96 +: 32] = 32'd89;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 4'b1000, 4'b0000, a, d);
            check("t4_ready", 32'(last_ready), 32'd8);
            check("t4_regwrite", 32'(RegWrite), 32'd0);
        end
        check("t4_drop", 32'(DropCount), 32'd2);

        // 5: accepted write cancelled by a reset on the next edge
        a[4:0] = 5'd5; d[31:0] = 32'd37;
        step(1'b0, 4'b0001, 4'b0000, a, d);
        check("t5_regwrite_pre", 32'(RegWrite), 32'd1);
        step(1'b1, 4'b0000, 4'b0000, a, d);
        check("t5_regwrite", 32'(RegWrite), 32'd0);
        check("t5_wreg", 32'(WriteRegister), 32'd0);
        check("t5_wdata", WriteData, 32'd0);
        check("t5_drop", 32'(DropCount), 32'd0);
        check("t5_rf5", tb_rf[5], 32'd0);

        // 6: lock released when the owner goes idle
        a[10 +: 5] = 5'd9; a[0 +: 5] = 5'd10;
        step(1'b0, 4'b0100, 4'b0100, a, d);
        check("t6_gid_lock", 32'(GrantId), 32'd2);
        step(1'b0, 4'b0001, 4'b0000, a, d);
        check("t6_release", 32'(last_ready), 32'd0);
        step(1'b0, 4'b0001, 4'b0000, a, d);
        check("t6_next", 32'(last_ready), 32'd1);
        check("t6_gid", 32'(GrantId), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] rv, rl;
            logic         rr;
            rv = 4'($urandom);
            rl = 4'($urandom) & 4'($urandom);
            rr = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                a[i*5 +: 5]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                d[i*32 +: 32] = $urandom;
            end
            step(rr, rv, rl, a, d);
        end

        step(1'b0, 4'b0000, 4'b0000, a, d);
        for (int k = 0; k < 32; k++) check("rf_final", tb_rf[k], m_rf[k]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
